// File: rtl/udp_rx_demux_if.sv
// UDP receive stream from the IP header clipper into udp_rx_demux.
// Handshake: valid-only. A word transfers on every clock edge where udpvalidin is high.
// There is no ready signal because the parser always accepts. udpsof, udpeof and crcmatch
// are only meaningful on a cycle where udpvalidin is high.
interface udp_rx_demux_if;
    logic        udpsof;
    logic        udpeof;
    logic        udpvalidin;
    logic [15:0] udpdatain;
    logic        crcmatch;

    modport master (output udpsof, udpeof, udpvalidin, udpdatain, crcmatch);
    modport slave  (input  udpsof, udpeof, udpvalidin, udpdatain, crcmatch);
endinterface

// File: rtl/udp_rx_demux.sv
// UDP receive parser and demultiplexer.
// Checks the UDP ones' complement checksum over the UDP header and payload, and maps the
// destination port onto one of NUM_CH channels. Control datagrams (length CTRL_LEN)
// produce qualified start/stop/sequence pulses. Bulk datagrams stream their payload out
// with a channel tag. All outputs are registered.
module udp_rx_demux #(
    parameter int          NUM_CH   = 4,
    parameter logic [15:0] CTRL_LEN = 16'd10,
    parameter logic [15:0] MAX_LEN  = 16'd1394
) (
    input  logic          clock,
    input  logic          reset,
    udp_rx_demux_if.slave udp,
    input  logic [15:0]   intudpport,
    output logic          startvalid,
    output logic          stopvalid,
    output logic          sequencevalid,
    output logic [14:0]   sequenceno,
    output logic          value,
    output logic [3:0]    ctrlch,
    output logic          datavalid,
    output logic          datasof,
    output logic          dataeof,
    output logic [15:0]   dataout,
    output logic [3:0]    datach,
    output logic [15:0]   length,
    output logic          checksummatch,
    output logic          checksumerr,
    output logic [15:0]   dropcount,
    output logic [2:0]    o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CTRL    = 3'd3,
        S_DROP    = 3'd4
    } state_t;

    state_t      r_state, w_state;
    logic [1:0]  r_wcnt;        // header word index; word 0 is consumed on udpsof
    logic [15:0] r_sum;         // running folded ones' complement sum
    logic [15:0] r_len;         // UDP length field
    logic [15:0] r_pcnt;        // payload words forwarded so far
    logic [15:0] r_exp;         // expected payload words, (len-8)/2
    logic        r_csum_zero;   // header checksum field was zero: checksum not in use
    logic        r_port_ok;
    logic        r_ctrl_got;    // control word already latched for this datagram
    logic [3:0]  r_ch;

    logic        r_startvalid, r_stopvalid, r_sequencevalid, r_value;
    logic [14:0] r_sequenceno;
    logic [3:0]  r_ctrlch, r_datach;
    logic        r_datavalid, r_datasof, r_dataeof;
    logic [15:0] r_dataout, r_length, r_dropcount;
    logic        r_checksummatch, r_checksumerr;

    logic        w_beat, w_sof;
    logic [16:0] w_add;
    logic [15:0] w_sum, w_off, w_cw, w_drop_next;
    logic        w_port_ok, w_hdr_bad, w_pass, w_cw_seq0;

    assign w_beat      = udp.udpvalidin;
    assign w_sof       = udp.udpvalidin & udp.udpsof;
    // End-around carry: fold bit 16 back in. The result cannot carry again.
    assign w_add       = {1'b0, r_sum} + {1'b0, udp.udpdatain};
    assign w_sum       = w_add[15:0] + {15'd0, w_add[16]};
    assign w_pass      = ((w_sum == 16'hFFFF) || r_csum_zero) && udp.crcmatch;
    // Subtracting first avoids overflow when intudpport+NUM_CH wraps past 16'hFFFF.
    assign w_off       = udp.udpdatain - intudpport;
    assign w_port_ok   = (udp.udpdatain >= intudpport) && (w_off < 16'(NUM_CH));
    assign w_hdr_bad   = !r_port_ok || (r_len < 16'd8) || (r_len > MAX_LEN) || r_len[0];
    // Control word used for the pulse decision: the current beat if not yet latched.
    assign w_cw        = r_ctrl_got ? {r_sequenceno, r_value} : udp.udpdatain;
    assign w_cw_seq0   = (w_cw[15:1] == 15'd0);
    assign w_drop_next = (r_dropcount == 16'hFFFF) ? r_dropcount : r_dropcount + 16'd1;

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state;
    end

    // FSM next state: udpsof always restarts the header; udpeof always returns to idle
    always_comb begin
        w_state = r_state;
        if (w_sof) begin
            w_state = udp.udpeof ? S_IDLE : S_HDR;
        end else if (w_beat) begin
            case (r_state)
                S_HDR: begin
                    if (udp.udpeof)            w_state = S_IDLE;
                    else if (r_wcnt == 2'd3) begin
                        if (w_hdr_bad)              w_state = S_DROP;
                        else if (r_len == CTRL_LEN) w_state = S_CTRL;
                        else                        w_state = S_PAYLOAD;
                    end
                end
                S_PAYLOAD, S_CTRL, S_DROP: if (udp.udpeof) w_state = S_IDLE;
                default: ;
            endcase
        end
    end

    // Datapath: header capture, checksum accumulation, payload forwarding and pulses
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wcnt          <= 2'd0;
            r_sum           <= 16'd0;
            r_len           <= 16'd0;
            r_pcnt          <= 16'd0;
            r_exp           <= 16'd0;
            r_csum_zero     <= 1'b0;
            r_port_ok       <= 1'b0;
            r_ctrl_got      <= 1'b0;
            r_ch            <= 4'd0;
            r_startvalid    <= 1'b0;
            r_stopvalid     <= 1'b0;
            r_sequencevalid <= 1'b0;
            r_sequenceno    <= 15'd0;
            r_value         <= 1'b0;
            r_ctrlch        <= 4'd0;
            r_datavalid     <= 1'b0;
            r_datasof       <= 1'b0;
            r_dataeof       <= 1'b0;
            r_dataout       <= 16'd0;
            r_datach        <= 4'd0;
            r_length        <= 16'd0;
            r_checksummatch <= 1'b0;
            r_checksumerr   <= 1'b0;
            r_dropcount     <= 16'd0;
        end else begin
            r_startvalid    <= 1'b0;
            r_stopvalid     <= 1'b0;
            r_sequencevalid <= 1'b0;
            r_datavalid     <= 1'b0;
            r_datasof       <= 1'b0;
            r_dataeof       <= 1'b0;
            r_checksummatch <= 1'b0;
            r_checksumerr   <= 1'b0;
            if (w_sof) begin
                // A new datagram aborts the current one. An open bulk stream is closed
                // with an empty end beat so the consumer can discard it.
                if (r_state == S_PAYLOAD) begin
                    r_datavalid   <= 1'b1;
                    r_dataeof     <= 1'b1;
                    r_dataout     <= 16'd0;
                    r_checksumerr <= 1'b1;
                end
                r_sum       <= udp.udpdatain;
                r_wcnt      <= 2'd1;
                r_pcnt      <= 16'd0;
                r_ctrl_got  <= 1'b0;
                r_csum_zero <= 1'b0;
                if (udp.udpeof) r_dropcount <= w_drop_next;
            end else if (w_beat) begin
                case (r_state)
                    S_HDR: begin
                        r_sum  <= w_sum;
                        r_wcnt <= r_wcnt + 2'd1;
                        case (r_wcnt)
                            2'd1: begin
                                r_port_ok <= w_port_ok;
                                r_ch      <= w_off[3:0];
                            end
                            2'd2:    r_len       <= udp.udpdatain;
                            2'd3:    r_csum_zero <= (udp.udpdatain == 16'd0);
                            default: ;
                        endcase
                        // An end before any payload word counts as an incomplete header.
                        if (udp.udpeof) begin
                            r_dropcount <= w_drop_next;
                        end else if (r_wcnt == 2'd3) begin
                            if (w_hdr_bad) begin
                                r_dropcount <= w_drop_next;
                            end else begin
                                r_length <= r_len - 16'd8;
                                r_exp    <= (r_len - 16'd8) >> 1;
                                if (r_len != CTRL_LEN) r_datach <= r_ch;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        r_sum <= w_sum;
                        if (udp.udpeof) begin
                            r_datavalid <= 1'b1;
                            r_dataeof   <= 1'b1;
                            r_datasof   <= (r_pcnt == 16'd0);
                            r_dataout   <= (r_pcnt < r_exp) ? udp.udpdatain : 16'd0;
                            if ((r_pcnt + 16'd1 == r_exp) && w_pass) r_checksummatch <= 1'b1;
                            else                                     r_checksumerr   <= 1'b1;
                        end else if (r_pcnt < r_exp) begin
                            r_datavalid <= 1'b1;
                            r_datasof   <= (r_pcnt == 16'd0);
                            r_dataout   <= udp.udpdatain;
                            r_pcnt      <= r_pcnt + 16'd1;
                        end
                    end
                    S_CTRL: begin
                        r_sum <= w_sum;
                        if (!r_ctrl_got) begin
                            r_sequenceno <= udp.udpdatain[15:1];
                            r_value      <= udp.udpdatain[0];
                            r_ctrlch     <= r_ch;
                            r_ctrl_got   <= 1'b1;
                        end
                        if (udp.udpeof) begin
                            if (w_pass) begin
                                r_checksummatch <= 1'b1;
                                r_startvalid    <= w_cw_seq0 && !w_cw[0];
                                r_stopvalid     <= w_cw_seq0 && w_cw[0];
                                r_sequencevalid <= !w_cw_seq0 && !w_cw[0];
                            end else begin
                                r_checksumerr <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign startvalid    = r_startvalid;
    assign stopvalid     = r_stopvalid;
    assign sequencevalid = r_sequencevalid;
    assign sequenceno    = r_sequenceno;
    assign value         = r_value;
    assign ctrlch        = r_ctrlch;
    assign datavalid     = r_datavalid;
    assign datasof       = r_datasof;
    assign dataeof       = r_dataeof;
    assign dataout       = r_dataout;
    assign datach        = r_datach;
    assign length        = r_length;
    assign checksummatch = r_checksummatch;
    assign checksumerr   = r_checksumerr;
    assign dropcount     = r_dropcount;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_udp_rx_demux.sv
// Testbench for udp_rx_demux: control-datagram vector table plus directed bulk, drop,
// abort and reset sequences. Payload words are scoreboarded through exp_q.
module tb_udp_rx_demux;
    localparam logic [15:0] BASE = 16'd5000;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] intudpport = BASE;
    logic        startvalid, stopvalid, sequencevalid, value;
    logic [14:0] sequenceno;
    logic [3:0]  ctrlch, datach;
    logic        datavalid, datasof, dataeof, checksummatch, checksumerr;
    logic [15:0] dataout, length, dropcount;
    logic [2:0]  o_dbg_state;

    udp_rx_demux_if u_if();

    udp_rx_demux dut (
        .clock(clock), .reset(reset), .udp(u_if), .intudpport(intudpport),
        .startvalid(startvalid), .stopvalid(stopvalid), .sequencevalid(sequencevalid),
        .sequenceno(sequenceno), .value(value), .ctrlch(ctrlch),
        .datavalid(datavalid), .datasof(datasof), .dataeof(dataeof), .dataout(dataout),
        .datach(datach), .length(length), .checksummatch(checksummatch),
        .checksumerr(checksumerr), .dropcount(dropcount), .o_dbg_state(o_dbg_state)
    );

    // ---------------- monitor ----------------
    int n_start = 0, n_stop = 0, n_seqv = 0, n_match = 0, n_err = 0;
    int n_dv = 0, n_sof = 0, n_eof = 0;
    logic [15:0] got_q[$];

    always @(negedge clock) begin
        if (startvalid)    n_start++;
        if (stopvalid)     n_stop++;
        if (sequencevalid) n_seqv++;
        if (checksummatch) n_match++;
        if (checksumerr)   n_err++;
        if (datavalid) begin
            n_dv++;
            if (datasof) n_sof++;
            if (dataeof) n_eof++;
            got_q.push_back(dataout);
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    int got_rd = 0;
    int b_start, b_stop, b_seqv, b_match, b_err, b_dv, b_sof, b_eof;
    int exp_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic snap();
        b_start = n_start; b_stop = n_stop; b_seqv = n_seqv; b_match = n_match;
        b_err = n_err; b_dv = n_dv; b_sof = n_sof; b_eof = n_eof;
    endtask

    task automatic check_deltas(input string tag, input int es, input int et, input int eq,
                                input int em, input int ee, input int edv, input int esof,
                                input int eeof);
        check({tag, "_start_cnt"}, n_start - b_start, es);
        check({tag, "_stop_cnt"},  n_stop - b_stop,   et);
        check({tag, "_seqv_cnt"},  n_seqv - b_seqv,   eq);
        check({tag, "_match_cnt"}, n_match - b_match, em);
        check({tag, "_err_cnt"},   n_err - b_err,     ee);
        check({tag, "_dv_cnt"},    n_dv - b_dv,       edv);
        check({tag, "_sof_cnt"},   n_sof - b_sof,     esof);
        check({tag, "_eof_cnt"},   n_eof - b_eof,     eeof);
    endtask

    task automatic compare_data(input string tag);
        logic [15:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_rd < got_q.size()) begin
                check({tag, "_dataout"}, got_q[got_rd], e);
                got_rd++;
            end else begin
                check({tag, "_data_missing"}, got_rd, got_rd + 1);
            end
        end
        check({tag, "_data_extra"}, got_q.size(), got_rd);
        got_rd = got_q.size();
    endtask

    // ---------------- driver ----------------
    logic [15:0] tx_q[$];
    logic [15:0] pl_q[$];

    function automatic logic [15:0] ones_sum();
        logic [16:0] t;
        logic [15:0] s;
        s = 16'd0;
        foreach (tx_q[i]) begin
            t = {1'b0, s} + {1'b0, tx_q[i]};
            s = t[15:0] + {15'd0, t[16]};
        end
        return s;
    endfunction

    // cmode: 0 = wrong checksum, 1 = correct checksum, 2 = checksum field zero
    task automatic build(input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] len, input logic [1:0] cmode);
        logic [15:0] c, bad;
        tx_q.delete();
        tx_q.push_back(src);
        tx_q.push_back(dst);
        tx_q.push_back(len);
        tx_q.push_back(16'h0000);
        foreach (pl_q[i]) tx_q.push_back(pl_q[i]);
        c   = ~ones_sum();
        bad = c ^ 16'h5A5A;
        if (bad == 16'h0000) bad = 16'h1111;
        case (cmode)
            2'd0:    tx_q[3] = bad;
            2'd1:    tx_q[3] = c;
            default: tx_q[3] = 16'h0000;
        endcase
    endtask

    task automatic idle(input int n);
        u_if.udpvalidin = 1'b0;
        u_if.udpsof     = 1'b0;
        u_if.udpeof     = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_word(input bit s, input bit e, input logic [15:0] d);
        u_if.udpsof     = s;
        u_if.udpeof     = e;
        u_if.udpdatain  = d;
        u_if.udpvalidin = 1'b1;
        @(posedge clock);
        #1;
        u_if.udpvalidin = 1'b0;
        u_if.udpsof     = 1'b0;
        u_if.udpeof     = 1'b0;
    endtask

    task automatic send_tx(input int n, input bit do_eof, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) idle($urandom_range(0, 2));
            send_word(i == 0, do_eof && (i == n - 1), tx_q[i]);
        end
    endtask

    // ---------------- control vector table ----------------
    typedef struct {
        logic [15:0] src;
        logic [3:0]  ch;
        logic [15:0] cw;
        logic [1:0]  cmode;
        logic        crc;
        logic        e_start, e_stop, e_seq, e_match, e_err;
        logic [14:0] e_seqno;
    } ctrl_vec_t;

    ctrl_vec_t cv[9];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        cv[0] = '{16'h1234, 4'd2, 16'h0000, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 15'd0};
        cv[1] = '{16'h1234, 4'd2, 16'h0006, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15'd3};
        cv[2] = '{16'h0BEE, 4'd1, 16'h0001, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 15'd0};
        cv[3] = '{16'h0BEE, 4'd0, 16'h0008, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 15'd4};
        cv[4] = '{16'h7777, 4'd3, 16'h0009, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'd4};
        cv[5] = '{16'hFFF0, 4'd2, 16'hFFFE, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 15'h7FFF};
        cv[6] = '{16'hFFF0, 4'd2, 16'hFFFE, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15'h7FFF};
        cv[7] = '{16'hABCD, 4'd1, 16'h0001, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 15'd0};
        cv[8] = '{16'hABCD, 4'd1, 16'h0001, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15'd0};

        u_if.udpsof = 1'b0; u_if.udpeof = 1'b0; u_if.udpvalidin = 1'b0;
        u_if.udpdatain = 16'd0; u_if.crcmatch = 1'b1;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_datavalid", datavalid, 0);
        check("rst_startvalid", startvalid, 0);
        check("rst_checksumerr", checksumerr, 0);
        check("rst_dropcount", dropcount, 0);
        check("rst_length", length, 0);
        check("rst_state", o_dbg_state, 0);
        reset = 1'b1;

        // Control datagrams from the table
        for (int k = 0; k < 9; k++) begin
            snap();
            pl_q.delete();
            pl_q.push_back(cv[k].cw);
            build(cv[k].src, BASE + {12'd0, cv[k].ch}, 16'd10, cv[k].cmode);
            u_if.crcmatch = cv[k].crc;
            send_tx(tx_q.size(), 1'b1, 1'b0);
            check($sformatf("ctrl%0d_match_next", k), checksummatch, cv[k].e_match);
            check($sformatf("ctrl%0d_err_next", k), checksumerr, cv[k].e_err);
            check($sformatf("ctrl%0d_start_next", k), startvalid, cv[k].e_start);
            idle(2);
            check_deltas($sformatf("ctrl%0d", k), cv[k].e_start, cv[k].e_stop, cv[k].e_seq,
                         cv[k].e_match, cv[k].e_err, 0, 0, 0);
            check($sformatf("ctrl%0d_seqno", k), sequenceno, cv[k].e_seqno);
            check($sformatf("ctrl%0d_value", k), value, cv[k].cw[0]);
            check($sformatf("ctrl%0d_ctrlch", k), ctrlch, cv[k].ch);
        end
        u_if.crcmatch = 1'b1;

        // Full-size bulk datagram on channel 0 with input gaps
        snap();
        pl_q.delete();
        for (int i = 0; i < 693; i++) pl_q.push_back(16'(i * 7 + 3));
        build(16'h0400, BASE, 16'd1394, 2'd1);
        foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
        send_tx(tx_q.size(), 1'b1, 1'b1);
        check("bulk_eof_dataeof", dataeof, 1);
        check("bulk_eof_match", checksummatch, 1);
        check("bulk_eof_err", checksumerr, 0);
        idle(2);
        check_deltas("bulk", 0, 0, 0, 1, 0, 693, 1, 1);
        check("bulk_length", length, 16'd1386);
        check("bulk_datach", datach, 0);
        compare_data("bulk");

        // Bulk on channel 3, FCS bad
        snap();
        pl_q.delete();
        for (int i = 0; i < 6; i++) pl_q.push_back(16'(16'h0100 + i));
        build(16'h0022, BASE + 16'd3, 16'd20, 2'd1);
        foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
        u_if.crcmatch = 1'b0;
        send_tx(tx_q.size(), 1'b1, 1'b0);
        u_if.crcmatch = 1'b1;
        idle(2);
        check_deltas("bulkfcs", 0, 0, 0, 0, 1, 6, 1, 1);
        check("bulkfcs_datach", datach, 3);
        check("bulkfcs_length", length, 12);
        compare_data("bulkfcs");

        // Bulk ends early: length says 6 words, only 4 arrive
        snap();
        pl_q.delete();
        for (int i = 0; i < 4; i++) pl_q.push_back(16'(16'h0A00 + i));
        build(16'h0033, BASE + 16'd1, 16'd20, 2'd1);
        foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
        send_tx(tx_q.size(), 1'b1, 1'b0);
        idle(2);
        check_deltas("short", 0, 0, 0, 0, 1, 4, 1, 1);
        compare_data("short");

        // Bulk runs long: length says 2 words, 4 arrive; extra words not forwarded
        snap();
        pl_q.delete();
        for (int i = 0; i < 4; i++) pl_q.push_back(16'(16'h0B00 + i));
        build(16'h0044, BASE + 16'd1, 16'd12, 2'd1);
        exp_q.push_back(16'h0B00);
        exp_q.push_back(16'h0B01);
        exp_q.push_back(16'h0000);
        send_tx(tx_q.size(), 1'b1, 1'b0);
        idle(2);
        check_deltas("long", 0, 0, 0, 0, 1, 3, 1, 1);
        compare_data("long");

        // Drops: bad port, short, oversize, odd length, early eof, sof+eof same beat
        snap();
        pl_q.delete();
        pl_q.push_back(16'h0000);
        build(16'h0055, BASE + 16'd4, 16'd10, 2'd1);
        send_tx(tx_q.size(), 1'b1, 1'b0);
        exp_drop++;
        idle(1);
        check("drop_port", dropcount, exp_drop);
        build(16'h0055, BASE, 16'd7, 2'd1);
        send_tx(tx_q.size(), 1'b1, 1'b0);
        exp_drop++;
        idle(1);
        check("drop_len7", dropcount, exp_drop);
        build(16'h0055, BASE, 16'd1396, 2'd1);
        send_tx(tx_q.size(), 1'b1, 1'b0);
        exp_drop++;
        build(16'h0055, BASE, 16'd13, 2'd1);
        send_tx(tx_q.size(), 1'b1, 1'b0);
        exp_drop++;
        build(16'h0055, BASE, 16'd10, 2'd1);
        send_tx(3, 1'b1, 1'b0);
        exp_drop++;
        send_tx(1, 1'b1, 1'b0);
        exp_drop++;
        idle(2);
        check("drop_total", dropcount, exp_drop);
        check_deltas("drop", 0, 0, 0, 0, 0, 0, 0, 0);

        // Abort: new udpsof after 10 payload words, followed by a control datagram
        snap();
        pl_q.delete();
        for (int i = 0; i < 46; i++) pl_q.push_back(16'(16'h0C00 + i));
        build(16'h0066, BASE, 16'd100, 2'd1);
        for (int i = 0; i < 10; i++) exp_q.push_back(pl_q[i]);
        exp_q.push_back(16'h0000);
        send_tx(14, 1'b0, 1'b0);
        pl_q.delete();
        pl_q.push_back(16'h0000);
        build(16'h0077, BASE + 16'd1, 16'd10, 2'd1);
        send_word(1'b1, 1'b0, tx_q[0]);
        check("abort_datavalid", datavalid, 1);
        check("abort_dataeof", dataeof, 1);
        check("abort_dataout", dataout, 0);
        check("abort_err", checksumerr, 1);
        for (int i = 1; i < 5; i++) send_word(1'b0, i == 4, tx_q[i]);
        check("abort_ctrl_start", startvalid, 1);
        check("abort_ctrl_match", checksummatch, 1);
        idle(2);
        check_deltas("abort", 1, 0, 0, 1, 1, 11, 1, 1);
        check("abort_ctrlch", ctrlch, 1);
        compare_data("abort");

        // Reset in the middle of a bulk datagram; the remainder must be ignored
        snap();
        pl_q.delete();
        for (int i = 0; i < 6; i++) pl_q.push_back(16'(16'h0D00 + i));
        build(16'h0088, BASE + 16'd2, 16'd20, 2'd1);
        exp_q.push_back(16'h0D00);
        exp_q.push_back(16'h0D01);
        send_tx(6, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_drop = 0;
        check("midrst_datavalid", datavalid, 0);
        check("midrst_dropcount", dropcount, exp_drop);
        check("midrst_state", o_dbg_state, 0);
        check("midrst_datach", datach, 0);
        for (int i = 6; i < 10; i++) send_word(1'b0, i == 9, tx_q[i]);
        idle(2);
        check_deltas("midrst", 0, 0, 0, 0, 0, 2, 1, 0);
        check("midrst_drop_after", dropcount, exp_drop);
        compare_data("midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
